// File: rtl/ifetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_unit_pkg
// Shared defines for the fetch front end: next-PC select codes used by the
// redirect path, immediate-generator select codes, and a small address helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ifetch_unit_pkg;

    // Next-PC target select, driven by the branch/jump resolution logic
    localparam logic [1:0] NPC_PCIMM = 2'd0;   // br_pc + ext
    localparam logic [1:0] NPC_JALR  = 2'd1;   // (rs1 + ext) & ~1

    // Immediate generator format select (consumer of sext_din)
    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_S = 3'd1;
    localparam logic [2:0] SEXT_B = 3'd2;
    localparam logic [2:0] SEXT_U = 3'd3;
    localparam logic [2:0] SEXT_J = 3'd4;

    // Instruction memory only serves whole words, so the two LSBs are cleared
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
// Instruction-memory request/response bus.
//   imem_req    fetch request (master -> slave)
//   imem_addr   word-aligned byte address (master -> slave)
//   imem_gnt    request accepted (slave -> master)
//   imem_rvalid response valid (slave -> master)
//   imem_rdata  instruction word (slave -> master)
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_npc.sv
// ---------------------------------------------------------------------------
// ifetch_npc
// Combinational redirect-target generator.
//   i_npc_op  target select (NPC_PCIMM / NPC_JALR)
//   i_br_pc   PC of the redirecting instruction
//   i_ext     sign-extended immediate
//   i_rs1     register operand for JALR
//   o_target  word-aligned redirect target (32-bit wrap)
// ---------------------------------------------------------------------------
module ifetch_npc
    import ifetch_unit_pkg::*;
(
    input  logic [1:0]  i_npc_op,
    input  logic [31:0] i_br_pc,
    input  logic [31:0] i_ext,
    input  logic [31:0] i_rs1,
    output logic [31:0] o_target
);

    logic [31:0] w_sum;

    // Raw target sum for the selected redirect kind
    always_comb begin
        w_sum = 32'd0;
        case (i_npc_op)
            NPC_PCIMM: w_sum = i_br_pc + i_ext;
            NPC_JALR:  w_sum = (i_rs1 + i_ext) & ~32'd1;
            default:   w_sum = i_br_pc + i_ext;
        endcase
    end

    assign o_target = word_align(w_sum);

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Single-outstanding instruction fetch unit with a one-entry output register
// and redirect (branch/jump) handling that squashes the in-flight response.
//   cpu_clk, cpu_rst        clock, synchronous active-high reset
//   redirect, npc_op,       taken branch/jump and target operands
//   br_pc, ext, rs1
//   imem                    instruction-memory bus (master side)
//   inst_valid/inst_ready   output handshake
//   inst, inst_pc, inst_pc4 fetched word, its PC, and PC+4
//   sext_din                inst[31:7] for the immediate generator
// ---------------------------------------------------------------------------
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          redirect,
    input  logic [1:0]    npc_op,
    input  logic [31:0]   br_pc,
    input  logic [31:0]   ext,
    input  logic [31:0]   rs1,
    ifetch_unit_if.master imem,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    output logic [31:0]   inst_pc4,
    input  logic          inst_ready,
    output logic [24:0]   sext_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_seq, w_pc_nxt;
    // Address of the current request; kept apart from r_pc so a redirect in
    // REQ can retarget r_pc while the bus address stays stable until gnt.
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_drop, w_drop_nxt;
    logic        r_inst_valid, w_inst_valid_nxt;
    logic [31:0] r_inst, r_inst_pc;
    logic        w_load;
    logic [31:0] w_target;

    ifetch_npc u_npc (
        .i_npc_op (npc_op),
        .i_br_pc  (br_pc),
        .i_ext    (ext),
        .i_rs1    (rs1),
        .o_target (w_target)
    );

    // Next-state, PC, drop flag and output-register load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_pc_seq    = r_pc;
        w_addr_nxt  = r_addr;
        w_drop_nxt  = r_drop;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A redirect empties the output slot, so it also frees us to fetch
                if (redirect || !r_inst_valid || inst_ready) begin
                    w_state_nxt = S_REQ;
                    w_addr_nxt  = redirect ? w_target : r_pc;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (imem.imem_gnt) begin
                    w_state_nxt = S_WAIT;
                    // A request already marked for dropping belongs to the old
                    // path; r_pc already holds the redirect target.
                    if (!r_drop) begin
                        w_pc_seq = r_pc + 32'd4;
                    end else begin
                        w_pc_seq = r_pc;
                    end
                end else begin
                    w_state_nxt = S_REQ;
                end
                if (redirect) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_drop_nxt = r_drop;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    // The single outstanding response retires here either way
                    w_state_nxt = S_IDLE;
                    w_drop_nxt  = 1'b0;
                    w_load      = !r_drop && !redirect;
                end else if (redirect) begin
                    w_drop_nxt  = 1'b1;
                end else begin
                    w_drop_nxt  = r_drop;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_drop_nxt  = 1'b0;
            end
        endcase

        // Redirect wins over the sequential PC update
        if (redirect) begin
            w_pc_nxt = w_target;
        end else begin
            w_pc_nxt = w_pc_seq;
        end

        if (redirect) begin
            w_inst_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_inst_valid_nxt = 1'b1;
        end else if (inst_ready) begin
            w_inst_valid_nxt = 1'b0;
        end else begin
            w_inst_valid_nxt = r_inst_valid;
        end
    end

    // State, PC and output register update
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_addr       <= w_addr_nxt;
            r_drop       <= w_drop_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            if (w_load) begin
                r_inst    <= imem.imem_rdata;
                r_inst_pc <= r_addr;
            end
        end
    end

    assign imem.imem_req  = (r_state == S_REQ);
    assign imem.imem_addr = r_addr;

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_pc4   = r_inst_pc + 32'd4;
    assign sext_din   = r_inst[31:7];

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Directed bench for ifetch_unit. A memory responder grants a bounded number
// of requests with a programmable response latency; expected request
// addresses and delivered instructions are queued by the stimulus and
// consumed by the responder / output monitor.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        redirect;
    logic [1:0]  npc_op;
    logic [31:0] br_pc, ext, rs1;
    logic        inst_valid;
    logic [31:0] inst, inst_pc, inst_pc4;
    logic        inst_ready;
    logic [24:0] sext_din;

    ifetch_unit_if imem_bus();

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .redirect   (redirect),
        .npc_op     (npc_op),
        .br_pc      (br_pc),
        .ext        (ext),
        .rs1        (rs1),
        .imem       (imem_bus),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_pc4   (inst_pc4),
        .inst_ready (inst_ready),
        .sext_din   (sext_din)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    int gnt_limit = 0;
    int gnt_count = 0;
    int rv_lat    = 1;

    logic [31:0] mon_pc, mon_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C) return 32'h0050_0093;
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a, input logic deliver);
        exp_addr_q.push_back(a);
        if (deliver) begin
            exp_pc_q.push_back(a);
            exp_inst_q.push_back(mem_word(a));
        end
    endtask

    task automatic wait_gnt(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge cpu_clk);
            seen = imem_bus.imem_gnt;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge cpu_clk);
            seen = inst_valid;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge cpu_clk);
            seen = imem_bus.imem_req;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80; i++) begin
            @(negedge cpu_clk);
            if (exp_addr_q.size() == 0 && exp_pc_q.size() == 0) break;
        end
        chk(tag, 32'(exp_addr_q.size() + exp_pc_q.size()), 32'd0);
    endtask

    // Assumes the caller sits just after a rising edge; redirect is high for one cycle
    task automatic do_redirect(input logic [1:0] op, input logic [31:0] bp,
                               input logic [31:0] e, input logic [31:0] r);
        redirect = 1'b1;
        npc_op   = op;
        br_pc    = bp;
        ext      = e;
        rs1      = r;
        drive_step();
        redirect = 1'b0;
    endtask

    // Memory responder: grants while budget remains, answers after rv_lat cycles
    initial begin : responder
        logic        busy;
        int          cnt;
        logic [31:0] paddr;
        busy = 1'b0;
        cnt  = 0;
        paddr = 32'd0;
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'd0;
        forever begin
            @(posedge cpu_clk);
            #2;
            imem_bus.imem_gnt    = 1'b0;
            imem_bus.imem_rvalid = 1'b0;
            if (busy) begin
                if (cnt <= 1) begin
                    imem_bus.imem_rvalid = 1'b1;
                    imem_bus.imem_rdata  = mem_word(paddr);
                    busy = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end else if (imem_bus.imem_req === 1'b1 && gnt_count < gnt_limit) begin
                imem_bus.imem_gnt = 1'b1;
                gnt_count++;
                busy  = 1'b1;
                cnt   = rv_lat;
                paddr = imem_bus.imem_addr;
                chk("req_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
                if (exp_addr_q.size() != 0) chk("imem_addr", imem_bus.imem_addr, exp_addr_q.pop_front());
            end
        end
    end

    // Output monitor: a handshake in a redirect or reset cycle is not a delivery
    always @(negedge cpu_clk) begin
        if (inst_valid === 1'b1 && inst_ready && !redirect && !cpu_rst) begin
            chk("deliver_expected", {31'd0, exp_pc_q.size() != 0}, 32'd1);
            if (exp_pc_q.size() != 0) begin
                mon_pc   = exp_pc_q.pop_front();
                mon_inst = exp_inst_q.pop_front();
                chk("inst", inst, mon_inst);
                chk("inst_pc", inst_pc, mon_pc);
                chk("inst_pc4", inst_pc4, mon_pc + 32'd4);
                chk("sext_din", {7'd0, sext_din}, {7'd0, mon_inst[31:7]});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        cpu_rst    = 1'b1;
        redirect   = 1'b0;
        npc_op     = NPC_PCIMM;
        br_pc      = 32'd0;
        ext        = 32'd0;
        rs1        = 32'd0;
        inst_ready = 1'b1;
        repeat (3) @(posedge cpu_clk);

        // Reset state
        @(negedge cpu_clk);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_pc4", inst_pc4, 32'd4);
        chk("rst_sext_din", {7'd0, sext_din}, 32'd0);

        // Back-to-back sequential fetch 0,4,8 with immediate gnt, 1-cycle rvalid
        rv_lat = 1;
        expect_fetch(32'h0, 1'b1);
        expect_fetch(32'h4, 1'b1);
        expect_fetch(32'h8, 1'b1);
        gnt_limit = gnt_limit + 3;
        drive_step();
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        chk("first_cycle_idle", {31'd0, imem_bus.imem_req}, 32'd0);
        @(negedge cpu_clk);
        chk("second_cycle_req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("second_cycle_addr", imem_bus.imem_addr, 32'h0);
        @(negedge cpu_clk);
        chk("latency_rvalid_cycle", {31'd0, inst_valid}, 32'd0);
        @(negedge cpu_clk);
        chk("latency_valid_cycle", {31'd0, inst_valid}, 32'd1);
        wait_drain("seq_drain");

        // Backpressure: output held for 5 cycles, no new request
        drive_step();
        inst_ready = 1'b0;
        expect_fetch(32'hC, 1'b1);
        gnt_limit = gnt_limit + 1;
        wait_valid("hold_valid");
        for (int i = 0; i < 5; i++) begin
            chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, 32'h0050_0093);
            chk("hold_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
            @(negedge cpu_clk);
        end
        drive_step();
        inst_ready = 1'b1;
        wait_req("resume_req");
        chk("resume_addr", imem_bus.imem_addr, 32'h10);

        // Redirect (PC+imm) while waiting for the response
        drive_step();
        rv_lat = 3;
        expect_fetch(32'h10, 1'b0);
        gnt_limit = gnt_limit + 1;
        wait_gnt("wait_redirect_gnt");
        drive_step();
        do_redirect(NPC_PCIMM, 32'h100, 32'hFFFF_FFF0, 32'h0);
        rv_lat = 1;
        expect_fetch(32'hF0, 1'b1);
        gnt_limit = gnt_limit + 1;
        wait_drain("wait_redirect_drain");

        // Redirect (JALR) while the request is stalled waiting for gnt
        wait_req("jalr_req");
        chk("jalr_req_addr", imem_bus.imem_addr, 32'hF4);
        drive_step();
        do_redirect(NPC_JALR, 32'h0, 32'h4, 32'h203);
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            chk("jalr_req_held", {31'd0, imem_bus.imem_req}, 32'd1);
            chk("jalr_addr_held", imem_bus.imem_addr, 32'hF4);
        end
        drive_step();
        rv_lat = 2;
        expect_fetch(32'hF4, 1'b0);
        expect_fetch(32'h204, 1'b1);
        gnt_limit = gnt_limit + 2;
        wait_drain("jalr_drain");

        // Redirect coincident with a valid/ready handshake
        wait_req("coinc_req");
        chk("coinc_req_addr", imem_bus.imem_addr, 32'h208);
        drive_step();
        inst_ready = 1'b0;
        rv_lat = 1;
        expect_fetch(32'h208, 1'b0);
        gnt_limit = gnt_limit + 1;
        wait_valid("coinc_valid");
        chk("coinc_held_pc", inst_pc, 32'h208);
        drive_step();
        inst_ready = 1'b1;
        do_redirect(NPC_PCIMM, 32'h300, 32'h0, 32'h0);
        @(negedge cpu_clk);
        chk("coinc_valid_cleared", {31'd0, inst_valid}, 32'd0);
        expect_fetch(32'h300, 1'b1);
        gnt_limit = gnt_limit + 1;
        wait_drain("coinc_drain");

        // Two consecutive redirects, latest wins; then PC wraps past 0xFFFFFFFC
        wait_req("wrap_req");
        chk("wrap_req_addr", imem_bus.imem_addr, 32'h304);
        drive_step();
        redirect = 1'b1;
        npc_op   = NPC_PCIMM;
        br_pc    = 32'h500;
        ext      = 32'h0;
        drive_step();
        br_pc    = 32'hFFFF_FFF0;
        ext      = 32'h0000_000C;
        drive_step();
        redirect = 1'b0;
        expect_fetch(32'h304, 1'b0);
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0, 1'b1);
        gnt_limit = gnt_limit + 3;
        wait_drain("wrap_drain");

        // Reset mid-transaction; the late response lands in IDLE and is ignored
        wait_req("rst_mid_req");
        chk("rst_mid_addr", imem_bus.imem_addr, 32'h4);
        drive_step();
        rv_lat = 3;
        expect_fetch(32'h4, 1'b0);
        gnt_limit = gnt_limit + 1;
        wait_gnt("rst_mid_gnt");
        drive_step();
        cpu_rst = 1'b1;
        drive_step();
        @(negedge cpu_clk);
        chk("rst_mid_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_mid_valid_low", {31'd0, inst_valid}, 32'd0);
        drive_step();
        cpu_rst = 1'b0;
        rv_lat = 1;
        expect_fetch(32'h0, 1'b1);
        gnt_limit = gnt_limit + 1;
        @(negedge cpu_clk);
        chk("late_rvalid_present", {31'd0, imem_bus.imem_rvalid}, 32'd1);
        chk("late_rvalid_idle", {31'd0, imem_bus.imem_req}, 32'd0);
        @(negedge cpu_clk);
        chk("late_rvalid_ignored", {31'd0, inst_valid}, 32'd0);
        chk("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("post_rst_addr", imem_bus.imem_addr, 32'h0);
        wait_drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
